// File: rtl/jhash_req_arbiter.sv
// jhash_req_arbiter: round-robin sharing of one jenkins_hash core among NREQ word streams.
// Optional S_WAIT watchdog is compiled in when JHASH_ARB_TIMEOUT_EN is defined.
//
// state  | meaning
// S_IDLE | no message; pick next valid requester at/after rr pointer
// S_FEED | stream granted requester's words into the core
// S_WAIT | all words sent, waiting for jh_done (or watchdog)
// S_RESP | result held on res_* until res_ready
module jhash_req_arbiter #(
    parameter int NREQ        = 4,
    parameter int SW          = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*64-1:0] req_data,
    input  logic [NREQ*12-1:0] req_len,
    input  logic [NREQ-1:0]    req_last,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [SW-1:0]      res_src,
    output logic [31:0]        res_hash,
    output logic               res_err,
    output logic               jh_ce,
    output logic [63:0]        jh_id,
    output logic               jh_last,
    output logic [11:0]        jh_len,
    input  logic               jh_done,
    input  logic [31:0]        jh_dout,
    output logic               busy
);

    typedef enum logic [1:0] {S_IDLE, S_FEED, S_WAIT, S_RESP} state_t;

    localparam logic [SW:0] NREQ_W = (SW+1)'(NREQ);

    if (NREQ < 2 || NREQ > 16 || SW != $clog2(NREQ) || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535)
    begin : g_bad_param
        $error("jhash_req_arbiter: unsupported parameter set");
    end

    state_t         state, state_nxt;
    logic [SW-1:0]  ptr, grant, pick;
    logic [SW:0]    idx;
    logic [11:0]    cnt, len_q, eff_len;
    logic           err, xfer, is_last, len_zero, tmo_hit;
    logic [63:0]    data_arr [NREQ];
    logic [11:0]    len_arr  [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign data_arr[g] = req_data[64*g +: 64];
        assign len_arr[g]  = req_len[12*g +: 12];
    end

    // Walk downward so the lowest offset from the pointer wins.
    always_comb begin
        pick = ptr;
        idx  = '0;
        for (int i = NREQ-1; i >= 0; i--) begin
            idx = {1'b0, ptr} + (SW+1)'(i);
            if (idx >= NREQ_W) idx = idx - NREQ_W;
            if (req_valid[idx[SW-1:0]]) pick = idx[SW-1:0];
        end
    end

    // A zero length on the first word is run as a one-word message and flagged.
    assign len_zero = (cnt == 12'd0) && (len_arr[grant] == 12'd0);
    assign eff_len  = (cnt != 12'd0) ? len_q : (len_zero ? 12'd1 : len_arr[grant]);
    assign is_last  = (cnt + 12'd1 == eff_len);
    assign busy     = (state != S_IDLE);

`ifdef JHASH_ARB_TIMEOUT_EN
    logic [15:0] tmo_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                tmo_cnt <= '0;
        else if (state != S_WAIT)  tmo_cnt <= '0;
        else                       tmo_cnt <= tmo_cnt + 16'd1;
    end

    assign tmo_hit = (tmo_cnt == 16'(TIMEOUT_CYC));
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        xfer      = 1'b0;
        case (state)
            S_IDLE: if (|req_valid) state_nxt = S_FEED;
            S_FEED: begin
                req_ready[grant] = 1'b1;
                xfer             = req_valid[grant];
                if (xfer && is_last) state_nxt = S_WAIT;
            end
            S_WAIT: if (jh_done || tmo_hit) state_nxt = S_RESP;
            S_RESP: if (res_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ptr       <= '0;
            grant     <= '0;
            cnt       <= '0;
            len_q     <= '0;
            err       <= 1'b0;
            jh_ce     <= 1'b0;
            jh_id     <= '0;
            jh_last   <= 1'b0;
            jh_len    <= '0;
            res_valid <= 1'b0;
            res_src   <= '0;
            res_hash  <= '0;
            res_err   <= 1'b0;
        end else begin
            state   <= state_nxt;
            jh_ce   <= xfer;
            jh_last <= xfer & is_last;
            if (xfer) begin
                jh_id  <= data_arr[grant];
                jh_len <= eff_len;
                cnt    <= cnt + 12'd1;
                if (cnt == 12'd0) len_q <= eff_len;
                if (len_zero || (req_last[grant] != is_last)) err <= 1'b1;
            end
            case (state)
                S_IDLE: if (|req_valid) grant <= pick;
                S_WAIT: begin
                    if (jh_done) begin
                        res_valid <= 1'b1;
                        res_src   <= grant;
                        res_hash  <= jh_dout;
                        res_err   <= err;
                    end else if (tmo_hit) begin
                        res_valid <= 1'b1;
                        res_src   <= grant;
                        res_hash  <= '0;
                        res_err   <= 1'b1;
                    end
                end
                S_RESP: if (res_ready) begin
                    res_valid <= 1'b0;
                    res_err   <= 1'b0;
                    ptr       <= (grant == SW'(NREQ-1)) ? '0 : grant + SW'(1);
                    cnt       <= '0;
                    err       <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_jhash_req_arbiter.sv
// Directed bench for jhash_req_arbiter: requester script driver, a small hash-core model,
// a table of single-message vectors and hand-written multi-cycle sequences.
module tb_jhash_req_arbiter;
    localparam int NREQ = 4;
    localparam int SW   = 2;
`ifdef JHASH_ARB_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 1024;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NREQ-1:0]    req_valid, req_ready, req_last;
    logic [NREQ*64-1:0] req_data;
    logic [NREQ*12-1:0] req_len;
    logic               res_valid, res_ready, res_err, busy;
    logic [SW-1:0]      res_src;
    logic [31:0]        res_hash, jh_dout;
    logic               jh_ce, jh_last, jh_done;
    logic [63:0]        jh_id;
    logic [11:0]        jh_len;

    jhash_req_arbiter #(.NREQ(NREQ), .SW(SW), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .req_len(req_len), .req_last(req_last),
        .res_valid(res_valid), .res_ready(res_ready), .res_src(res_src),
        .res_hash(res_hash), .res_err(res_err),
        .jh_ce(jh_ce), .jh_id(jh_id), .jh_last(jh_last), .jh_len(jh_len),
        .jh_done(jh_done), .jh_dout(jh_dout), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] pat(input int s, input int k);
        return {4'hA, s[3:0], k[7:0], 48'h0123_4567_89AB};
    endfunction

    function automatic logic [31:0] fold(input logic [63:0] x);
        return x[63:32] ^ x[31:0] ^ 32'h5A5A_5A5A;
    endfunction

    // requester scripts
    int          sc_n [NREQ] = '{default: 0};
    int          sc_k [NREQ] = '{default: 0};
    int          sc_last [NREQ] = '{default: -1};
    logic [11:0] sc_len [NREQ] = '{default: 12'd0};
    logic [63:0] words [NREQ][8];
    logic [NREQ-1:0] acc;
    bit          gap_en = 1'b0;
    int          cyc;

    initial begin
        req_valid = '0; req_data = '0; req_len = '0; req_last = '0; acc = '0; cyc = 0;
        for (int i = 0; i < NREQ; i++) for (int k = 0; k < 8; k++) words[i][k] = '0;
        forever begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < NREQ; i++) if (acc[i]) begin sc_k[i]++; sc_n[i]--; end
            for (int i = 0; i < NREQ; i++) begin
                req_valid[i]        = (sc_n[i] > 0) && !(gap_en && (cyc % 3 == 1));
                req_data[64*i +: 64] = words[i][sc_k[i] & 7];
                req_len[12*i +: 12]  = sc_len[i];
                req_last[i]         = (sc_k[i] == sc_last[i]);
            end
            acc = req_valid & req_ready;
        end
    end

    // hash core model: answers 2 idle cycles after the last word with a fold of the words
    logic [63:0] id_x;
    int          ce_cnt, last_cnt, last_pos, dly;
    logic [11:0] last_len;
    bit          pend, core_en = 1'b1;

    initial begin
        jh_done = 1'b0; jh_dout = '0; id_x = '0; pend = 1'b0; dly = 0;
        ce_cnt = 0; last_cnt = 0; last_pos = 0; last_len = '0;
        forever begin
            @(negedge clk);
            jh_done = 1'b0;
            if (!rst_n) begin
                id_x = '0; pend = 1'b0; ce_cnt = 0; last_cnt = 0;
            end else if (jh_ce) begin
                ce_cnt++;
                id_x = id_x ^ jh_id;
                if (jh_last) begin
                    last_cnt++; last_pos = ce_cnt; last_len = jh_len; pend = 1'b1; dly = 2;
                end
            end else if (pend && core_en) begin
                if (dly > 0) dly--;
                else begin
                    jh_done = 1'b1; jh_dout = fold(id_x); id_x = '0; pend = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int s, input int len, input int nw, input int lastat,
                        input logic [63:0] w0, input logic [63:0] w1);
        for (int k = 0; k < 8; k++) words[s][k] = (k == 0) ? w0 : (k == 1) ? w1 : pat(s, k);
        sc_len[s] = 12'(len); sc_k[s] = 0; sc_last[s] = lastat; sc_n[s] = nw;
    endtask

    task automatic clear_scripts();
        for (int i = 0; i < NREQ; i++) sc_n[i] = 0;
    endtask

    task automatic wait_res(input string nm);
        int n;
        n = 0;
        while (!res_valid && n < 300) begin tick(); n++; end
        if (!res_valid) begin
            total++; bad++;
            $display("FAIL %s: res_valid timeout got 0 expected 1", nm);
        end
    endtask

    task automatic accept();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        ce_cnt = 0; last_cnt = 0;
    endtask

    typedef struct {
        int          src;
        int          len;
        int          nw;
        int          lastat;
        logic [63:0] w0;
        logic [63:0] w1;
        int          exp_ce;
        int          exp_len;
        bit          exp_err;
        bit          gap;
    } vec_t;

    vec_t        tbl [5];
    logic [63:0] x;
    int          exp_order [5] = '{0, 1, 2, 3, 0};
    int          n, t0;

    initial begin
        res_ready = 1'b0;
        tbl[0] = '{0, 2, 2, 1, 64'hffff_ffff_ffff_ffff, 64'h1234_5678_9abc_deff, 2, 2, 1'b0, 1'b0};
        tbl[1] = '{2, 3, 3, 1, pat(2, 0), pat(2, 1), 3, 3, 1'b1, 1'b0};  // early req_last
        tbl[2] = '{1, 0, 1, 0, pat(1, 0), pat(1, 1), 1, 1, 1'b1, 1'b0};  // len 0 -> 1, err
        tbl[3] = '{3, 1, 1, -1, pat(3, 0), pat(3, 1), 1, 1, 1'b1, 1'b0}; // missing req_last
        tbl[4] = '{1, 4, 6, 3, pat(1, 0), pat(1, 1), 4, 4, 1'b0, 1'b1};  // gaps, extra words

        #1;
        chk("rst req_ready", 64'(req_ready), 64'd0);
        chk("rst res_valid", 64'(res_valid), 64'd0);
        chk("rst jh_ce",     64'(jh_ce),     64'd0);
        chk("rst busy",      64'(busy),      64'd0);
        chk("rst res_hash",  64'(res_hash),  64'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 5; v++) begin
            gap_en = tbl[v].gap;
            load(tbl[v].src, tbl[v].len, tbl[v].nw, tbl[v].lastat, tbl[v].w0, tbl[v].w1);
            wait_res($sformatf("vec%0d", v));
            x = '0;
            for (int k = 0; k < tbl[v].exp_ce; k++)
                x = x ^ ((k == 0) ? tbl[v].w0 : (k == 1) ? tbl[v].w1 : pat(tbl[v].src, k));
            chk($sformatf("vec%0d res_src", v),  64'(res_src),  64'(tbl[v].src));
            chk($sformatf("vec%0d res_hash", v), 64'(res_hash), 64'(fold(x)));
            chk($sformatf("vec%0d res_err", v),  64'(res_err),  64'(tbl[v].exp_err));
            chk($sformatf("vec%0d ce count", v), 64'(ce_cnt),   64'(tbl[v].exp_ce));
            chk($sformatf("vec%0d last count", v), 64'(last_cnt), 64'd1);
            chk($sformatf("vec%0d last pos", v), 64'(last_pos), 64'(tbl[v].exp_ce));
            chk($sformatf("vec%0d jh_len", v),   64'(last_len), 64'(tbl[v].exp_len));
            chk($sformatf("vec%0d busy", v),     64'(busy),     64'd1);
            gap_en = 1'b0;
            clear_scripts();
            accept();
            chk($sformatf("vec%0d idle after accept", v), {62'd0, res_valid, busy}, 64'd0);
        end

        // result held while res_ready is low; a waiting requester is not fed
        load(0, 1, 1, 0, pat(0, 0), pat(0, 1));
        wait_res("hold");
        load(1, 1, 1, 0, pat(1, 0), pat(1, 1));
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("hold res_valid", 64'(res_valid), 64'd1);
            chk("hold res_src",   64'(res_src),   64'd0);
            chk("hold res_hash",  64'(res_hash),  64'(fold(pat(0, 0))));
            chk("hold req_ready", 64'(req_ready), 64'd0);
            chk("hold ce count",  64'(ce_cnt),    64'd1);
        end
        accept();
        wait_res("after hold");
        chk("after hold src",  64'(res_src),  64'd1);
        chk("after hold hash", 64'(res_hash), 64'(fold(pat(1, 0))));
        chk("after hold ce",   64'(ce_cnt),   64'd1);
        clear_scripts();
        accept();

        // round robin from pointer 0 with all requesters pending
        rst_n = 1'b0; tick(); tick(); rst_n = 1'b1; tick();
        for (int i = 0; i < NREQ; i++) load(i, 1, 1, 0, pat(i, 0), pat(i, 1));
        for (int r = 0; r < 5; r++) begin
            wait_res($sformatf("rr%0d", r));
            chk($sformatf("rr%0d res_src", r), 64'(res_src), 64'(exp_order[r]));
            chk($sformatf("rr%0d res_hash", r), 64'(res_hash), 64'(fold(pat(exp_order[r], 0))));
            accept();
            if (r == 0) load(0, 1, 1, 0, pat(0, 0), pat(0, 1));
        end
        clear_scripts();

        // move pointer to 3, then reset in the middle of a message from req1
        load(2, 1, 1, 0, pat(2, 0), pat(2, 1));
        wait_res("pre-reset");
        chk("pre-reset src", 64'(res_src), 64'd2);
        clear_scripts();
        accept();
        load(1, 4, 4, 3, pat(1, 0), pat(1, 1));
        n = 0;
        while (ce_cnt < 1 && n < 100) begin tick(); n++; end
        chk("mid-feed reached", 64'(ce_cnt), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mrst req_ready", 64'(req_ready), 64'd0);
        chk("mrst jh_ce",     64'(jh_ce),     64'd0);
        chk("mrst jh_id",     jh_id,          64'd0);
        chk("mrst jh_len",    64'(jh_len),    64'd0);
        chk("mrst jh_last",   64'(jh_last),   64'd0);
        chk("mrst busy",      64'(busy),      64'd0);
        chk("mrst res",       {res_hash, 29'd0, res_valid, res_err, 1'b0}, 64'd0);
        chk("mrst res_src",   64'(res_src),   64'd0);
        clear_scripts();
        tick(); tick();
        rst_n = 1'b1;
        tick();
        load(3, 1, 1, 0, pat(3, 0), pat(3, 1));
        load(1, 2, 2, 1, pat(1, 0), pat(1, 1));
        wait_res("post-reset");
        chk("post-reset src",  64'(res_src),  64'd1);
        chk("post-reset hash", 64'(res_hash), 64'(fold(pat(1, 0) ^ pat(1, 1))));
        chk("post-reset err",  64'(res_err),  64'd0);
        chk("post-reset ce",   64'(ce_cnt),   64'd2);
        accept();
        wait_res("post-reset 2nd");
        chk("post-reset 2nd src", 64'(res_src), 64'd3);
        clear_scripts();
        accept();

`ifdef JHASH_ARB_TIMEOUT_EN
        core_en = 1'b0;
        load(0, 1, 1, 0, pat(0, 0), pat(0, 1));
        n = 0; t0 = -1;
        while (!res_valid && n < 200) begin
            tick(); n++;
            if (jh_ce && t0 < 0) t0 = n;
        end
        chk("tmo res_valid", 64'(res_valid), 64'd1);
        chk("tmo latency",   64'(n - t0),    64'd17);
        chk("tmo res_err",   64'(res_err),   64'd1);
        chk("tmo res_hash",  64'(res_hash),  64'd0);
        clear_scripts();
        accept();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
